count_cmd_arbiter: RTL

Two-port command arbiter and sequencer for the 5-bit saturating up/down counter (load > down > up priority, saturates at 0/31, `low`/`high` flags). It shares the counter between two requesters, granting them round-robin. Each granted command runs to completion: LOAD, a multi-step UP or DOWN, or READ. The block drives the counter's `in`/`load`/`up`/`down` inputs, watches its value and `low`/`high` flags, and reports the result and any saturation with a one-cycle acknowledge.

---
 rtl/count_cmd_pkg.sv | 18 +
 rtl/rr_arb2.sv | 13 +
 rtl/count_cmd_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/count_cmd_pkg.sv
// Shared encodings for the counter command arbiter: op codes, FSM states and
// the default counter width.
package count_cmd_pkg;
  localparam int CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. ptr holds the id granted last; on a tie the
// other requester wins. ptr_nxt advances to the winner whenever upd is high.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  input  logic upd,
  output logic gnt_id,
  output logic ptr_nxt
);
  assign gnt_id  = (req0 & req1) ? ~ptr : req1;
  assign ptr_nxt = upd ? gnt_id : ptr;
endmodule

// File: rtl/count_cmd_arbiter.sv
// Shares one saturating up/down counter between two requesters. Each granted
// command (READ/LOAD/UP n/DOWN n) runs to completion, then acks for one cycle.
module count_cmd_arbiter
  import count_cmd_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             sat,
  output logic             busy,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic             cnt_down,
  input  logic [WIDTH-1:0] cnt_val,
  input  logic             cnt_low,
  input  logic             cnt_high
);
  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] val_q, rem_q, rem_d;
  logic             id_q, sat_q, sat_d, ptr_q, ptr_d;
  logic             gnt_id, grant, step_blk;

  assign grant = (state_q == IDLE) && (req0 || req1);

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .ptr     (ptr_q),
    .upd     (grant),
    .gnt_id  (gnt_id),
    .ptr_nxt (ptr_d)
  );

  // ptr_q=1 after reset so that a tie goes to req0 first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      val_q   <= '0;
      rem_q   <= '0;
      id_q    <= 1'b0;
      sat_q   <= 1'b0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        op_q  <= op_e'(gnt_id ? op1 : op0);
        val_q <= gnt_id ? val1 : val0;
        id_q  <= gnt_id;
      end
    end
  end

  // the flag that forbids the next step in the latched direction
  assign step_blk = (op_q == OP_UP) ? cnt_high : cnt_low;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sat_d    = sat_q;
    ack0     = 1'b0;
    ack1     = 1'b0;
    rdata    = '0;
    sat      = 1'b0;
    cnt_in   = '0;
    cnt_load = 1'b0;
    cnt_up   = 1'b0;
    cnt_down = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          rem_d   = gnt_id ? val1 : val0;
          sat_d   = 1'b0;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_LOAD: begin
            cnt_load = 1'b1;
            cnt_in   = val_q;
            state_d  = RESP;
          end
          OP_READ: state_d = RESP;
          default: begin
            if (rem_q == '0) begin
              state_d = RESP;
            end else if (step_blk) begin
              state_d = RESP;
              sat_d   = 1'b1;
            end else begin
              cnt_up   = (op_q == OP_UP);
              cnt_down = (op_q == OP_DOWN);
              rem_d    = rem_q - WIDTH'(1);
              if (rem_q == WIDTH'(1)) state_d = RESP;
            end
          end
        endcase
      end
      RESP: begin
        ack0    = ~id_q;
        ack1    = id_q;
        rdata   = cnt_val;
        sat     = sat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
